// File: rtl/ps2_scancode_rx_if.sv
// Scan-code event bus between the PS/2 receiver and the key decoder.
// Carries the raw PS/2 lines in and the decoded event strobes out.
interface ps2_scancode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_code;
    logic       rx_break;
    logic       rx_ext;
    logic       rx_valid;
    logic       rx_err;

    modport master (
        input  ps2_clk, ps2_data,
        output rx_code, rx_break, rx_ext, rx_valid, rx_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  rx_code, rx_break, rx_ext, rx_valid, rx_err
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard front end: sync, glitch filter, 11-bit framing, E0/F0 folding.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (0) on a filtered clock fall
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then accepting or dropping the byte
module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    ps2_scancode_rx_if.master bus
);
    localparam int FW = $clog2(FILTER_LEN) + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_s, data_s;
    logic                   clk_f;
    logic [FW-1:0]          fcnt;
    logic                   toggle, fall;

    state_t     state_q, state_d;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       par_q;
    logic       ext_pend, brk_pend;
    logic       accept, frame_err, timeout_hit;

    logic [7:0] code_q;
    logic       brk_q, ext_q, valid_q, err_q;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    assign toggle = (clk_s != clk_f) && (fcnt == FW'(FILTER_LEN - 1));
    assign fall   = toggle && clk_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_f <= 1'b1;
            fcnt  <= '0;
        end else if (clk_s == clk_f) begin
            fcnt <= '0;
        end else if (toggle) begin
            clk_f <= ~clk_f;
            fcnt  <= '0;
        end else begin
            fcnt <= fcnt + FW'(1);
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    logic [WW-1:0] wdog;

    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || toggle)
            wdog <= '0;
        else
            wdog <= wdog + WW'(1);
    end

    assign timeout_hit = (state_q != IDLE) && (wdog == WW'(TIMEOUT_CYCLES));
`else
    // Watchdog absent: the comparison is constant false, so a stalled frame waits forever.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        frame_err = 1'b0;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:   if (!data_s) state_d = DATA;
                DATA:   if (bit_idx == 3'd7) state_d = PARITY;
                PARITY: state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    if (((^shreg) ^ par_q) && data_s)
                        accept = 1'b1;
                    else
                        frame_err = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx  <= '0;
            shreg    <= '0;
            par_q    <= 1'b0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            code_q   <= '0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (fall && !timeout_hit) begin
                case (state_q)
                    IDLE: bit_idx <= '0;
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                    PARITY:  par_q <= data_s;
                    default: ;
                endcase
            end
            // Prefix bytes only arm flags; the following code byte carries them out.
            if (accept) begin
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    valid_q  <= 1'b1;
                    code_q   <= shreg;
                    brk_q    <= brk_pend;
                    ext_q    <= ext_pend;
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
            if (frame_err || timeout_hit) begin
                err_q    <= 1'b1;
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
            if (timeout_hit)
                shreg <= '0;
        end
    end

    assign bus.rx_code  = code_q;
    assign bus.rx_break = brk_q;
    assign bus.rx_ext   = ext_q;
    assign bus.rx_valid = valid_q;
    assign bus.rx_err   = err_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames, monitor pops expected events.
module tb_ps2_scancode_rx;
    localparam int HALF = 40;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_rise = 0;
    ev_t  sb[$];

    ps2_scancode_rx_if bus ();

    ps2_scancode_rx #(
        .SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic err, input logic [7:0] code, input logic brk, input logic ext);
        ev_t e;
        e.err = err; e.code = code; e.brk = brk; e.ext = ext;
        sb.push_back(e);
    endtask

    // Frame bits in wire order: start, d0..d7, parity, stop.
    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = fr[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
            last_rise = cyc;
        end
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par);
        send_bits({1'b1, par, b, 1'b0}, 11);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_code"},  bus.rx_code,  0);
        check({tag, "_brk"},   bus.rx_break, 0);
        check({tag, "_ext"},   bus.rx_ext,   0);
        check({tag, "_valid"}, bus.rx_valid, 0);
        check({tag, "_err"},   bus.rx_err,   0);
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.rx_valid || bus.rx_err)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: valid=%0b err=%0b code=%02h, none expected",
                         bus.rx_valid, bus.rx_err, bus.rx_code);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("ev_exclusive", {31'd0, bus.rx_valid & bus.rx_err}, 0);
                check("ev_is_err", {31'd0, bus.rx_err}, {31'd0, e.err});
                check("ev_code", {24'd0, bus.rx_code}, {24'd0, e.code});
                if (!e.err) begin
                    check("ev_break", {31'd0, bus.rx_break}, {31'd0, e.brk});
                    check("ev_ext",   {31'd0, bus.rx_ext},   {31'd0, e.ext});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        int delta;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Make code 0x29 (three ones, parity 0)
        expect_ev(1'b0, 8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0);

        // Break: F0 (four ones, parity 1) then 29
        send_frame(8'hF0, 1'b1);
        check("no_strobe_after_f0", sb.size(), 0);
        expect_ev(1'b0, 8'h29, 1'b1, 1'b0);
        send_frame(8'h29, 1'b0);

        // Extended break E0 F0 75, then plain 75
        expect_ev(1'b0, 8'h75, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h75, 1'b0);
        expect_ev(1'b0, 8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0);

        // Parity error on 0x76 keeps rx_code at 0x75, then a clean 0x76
        expect_ev(1'b1, 8'h75, 1'b0, 1'b0);
        send_frame(8'h76, 1'b1);
        expect_ev(1'b0, 8'h76, 1'b0, 1'b0);
        send_frame(8'h76, 1'b0);

        // 3-cycle clock glitch with data low must not look like a start bit
        bus.ps2_data = 1'b0;
        repeat (10) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        expect_ev(1'b0, 8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0);

        // Reset after start + 4 data bits
        send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midframe_rst");
        expect_ev(1'b0, 8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0);

        // Stall with clock high after 5 bits
`ifdef PS2_RX_TIMEOUT_EN
        expect_ev(1'b1, 8'h29, 1'b0, 1'b0);
        send_bits({1'b1, 1'b0, 8'h76, 1'b0}, 5);
        got = 1'b0;
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge clk);
            if (bus.rx_err) got = 1'b1;
        end
        check("timeout_err_seen", {31'd0, got}, 1);
        delta = cyc - last_rise;
        tests++;
        if (got && (delta < 1000 || delta > 1030)) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles expected 1000..1030", delta);
        end
`else
        send_bits({1'b1, 1'b0, 8'h76, 1'b0}, 5);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.rx_err) got = 1'b1;
        end
        check("stall_no_err", {31'd0, got}, 0);
        delta = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        expect_ev(1'b0, 8'h76, 1'b0, 1'b0);
        send_frame(8'h76, 1'b0);

        repeat (100) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
